// File: rtl/mips31_pkg.sv
// mips31_pkg: ALU operation codes and GPR write-data select encodings.
// The ID/EXE and EXE/MEM pipeline registers both use these constants.
package mips31_pkg;

    // ALU operation codes (v2.0 encoding)
    localparam logic [3:0] ALU_NOP  = 4'b0000;
    localparam logic [3:0] ALU_MOVN = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_ADDU = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0100;
    localparam logic [3:0] ALU_SUBU = 4'b0101;
    localparam logic [3:0] ALU_AND  = 4'b0110;
    localparam logic [3:0] ALU_OR   = 4'b0111;
    localparam logic [3:0] ALU_XOR  = 4'b1000;
    localparam logic [3:0] ALU_NOR  = 4'b1001;
    localparam logic [3:0] ALU_SLT  = 4'b1010;
    localparam logic [3:0] ALU_SLTU = 4'b1011;
    localparam logic [3:0] ALU_SRL  = 4'b1100;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_SLL  = 4'b1110;
    localparam logic [3:0] ALU_LUI  = 4'b1111;

    // GPR write-data source select
    localparam logic [1:0] WSEL_ALU = 2'b00;
    localparam logic [1:0] WSEL_MEM = 2'b01;
    localparam logic [1:0] WSEL_PC8 = 2'b10;

    // True for the trapping add/sub ops whose signed overflow matters
    function automatic logic is_trap_arith(input logic [3:0] code);
        return (code == ALU_ADD) || (code == ALU_SUB);
    endfunction

endpackage

// File: rtl/alu31.sv
// alu31: purely combinational ALU for the EXE stage.
// Shift ops take the value from opr2 and the amount from opr1[4:0].
module alu31
    import mips31_pkg::*;
(
    input  logic [31:0] opr1,
    input  logic [31:0] opr2,
    input  logic [3:0]  control,
    output logic [31:0] result,
    output logic        overflow,
    output logic        zero_opr2
);

    logic [31:0] sum;
    logic [31:0] diff;
    logic [4:0]  shamt;

    assign sum       = opr1 + opr2;
    assign diff      = opr1 - opr2;
    assign shamt     = opr1[4:0];
    assign zero_opr2 = (opr2 == 32'h0);

    // Result select per operation code
    always_comb begin
        result = 32'h0;
        case (control)
            ALU_MOVN: result = opr1;
            ALU_ADD,
            ALU_ADDU: result = sum;
            ALU_SUB,
            ALU_SUBU: result = diff;
            ALU_AND:  result = opr1 & opr2;
            ALU_OR:   result = opr1 | opr2;
            ALU_XOR:  result = opr1 ^ opr2;
            ALU_NOR:  result = ~(opr1 | opr2);
            ALU_SLT:  result = {31'h0, ($signed(opr1) < $signed(opr2))};
            ALU_SLTU: result = {31'h0, (opr1 < opr2)};
            ALU_SRL:  result = opr2 >> shamt;
            ALU_SRA:  result = $unsigned($signed(opr2) >>> shamt);
            ALU_SLL:  result = opr2 << shamt;
            ALU_LUI:  result = {opr2[15:0], 16'h0};
            default:  result = 32'h0;
        endcase
    end

    // Signed overflow: only the trapping add/sub report it
    always_comb begin
        overflow = 1'b0;
        case (control)
            ALU_ADD: overflow = (opr1[31] == opr2[31]) && (sum[31] != opr1[31]);
            ALU_SUB: overflow = (opr1[31] != opr2[31]) && (diff[31] != opr1[31]);
            default: overflow = 1'b0;
        endcase
    end

endmodule

// File: rtl/exe_mem_reg.sv
// exe_mem_reg: EXE stage ALU plus the EXE/MEM pipeline register.
// Optional feature macro: OVF_TRAP_EN (add/sub overflow suppresses the
// GPR write and records the first faulting PC in ovf_flag/ovf_epc).
//
// Advance control: flush has priority over ena. flush=1 loads a bubble
// (all mem_* zero); otherwise ena=1 captures the EXE stage and ena=0
// holds every mem_* output. Reset is synchronous and overrides both.
module exe_mem_reg
    import mips31_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        ena,
    input  logic        flush,
    input  logic [31:0] exe_alu_opr1_in,
    input  logic [31:0] exe_alu_opr2_in,
    input  logic [3:0]  exe_alu_control_in,
    input  logic        exe_GPR_we_in,
    input  logic [4:0]  exe_GPR_waddr_in,
    input  logic [1:0]  exe_GPR_wdata_select_in,
    input  logic [31:0] exe_GPR_rt_in,
    input  logic [31:0] exe_pc_in,
    input  logic [31:0] exe_instr_in,
    output logic [31:0] exe_fwd_result,
    output logic        exe_fwd_we,
    output logic [31:0] mem_alu_result_out,
    output logic [31:0] mem_GPR_rt_out,
    output logic [31:0] mem_pc_out,
    output logic [31:0] mem_instr_out,
    output logic        mem_GPR_we,
    output logic [4:0]  mem_GPR_waddr,
    output logic [1:0]  mem_GPR_wdata_select,
    output logic        ovf_flag,
    output logic [31:0] ovf_epc
);

    logic [31:0] alu_result;
    logic        alu_overflow;
    logic        alu_zero_opr2;
    logic        ovf_kill;
    logic        eff_we;

    alu31 u_alu (
        .opr1      (exe_alu_opr1_in),
        .opr2      (exe_alu_opr2_in),
        .control   (exe_alu_control_in),
        .result    (alu_result),
        .overflow  (alu_overflow),
        .zero_opr2 (alu_zero_opr2)
    );

`ifdef OVF_TRAP_EN
    assign ovf_kill = alu_overflow;
`else
    // Without trapping, add/sub behave exactly like addu/subu
    assign ovf_kill = 1'b0;
`endif

    // Effective write enable: squash NOP, movn with zero condition, and trapped overflow
    always_comb begin
        eff_we = exe_GPR_we_in;
        if (exe_alu_control_in == ALU_NOP)
            eff_we = 1'b0;
        if ((exe_alu_control_in == ALU_MOVN) && alu_zero_opr2)
            eff_we = 1'b0;
        if (ovf_kill)
            eff_we = 1'b0;
    end

    assign exe_fwd_result = alu_result;
    assign exe_fwd_we     = eff_we;

    // EXE/MEM register: reset, then flush (bubble), then ena (capture), else hold
    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            mem_alu_result_out   <= 32'h0;
            mem_GPR_rt_out       <= 32'h0;
            mem_pc_out           <= 32'h0;
            mem_instr_out        <= 32'h0;
            mem_GPR_we           <= 1'b0;
            mem_GPR_waddr        <= 5'h0;
            mem_GPR_wdata_select <= 2'h0;
        end else if (ena) begin
            mem_alu_result_out   <= alu_result;
            mem_GPR_rt_out       <= exe_GPR_rt_in;
            mem_pc_out           <= exe_pc_in;
            mem_instr_out        <= exe_instr_in;
            mem_GPR_we           <= eff_we;
            mem_GPR_waddr        <= exe_GPR_waddr_in;
            mem_GPR_wdata_select <= exe_GPR_wdata_select_in;
        end
    end

`ifdef OVF_TRAP_EN
    logic        ovf_flag_q;
    logic [31:0] ovf_epc_q;

    // Sticky overflow record: first faulting PC is kept until reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            ovf_flag_q <= 1'b0;
            ovf_epc_q  <= 32'h0;
        end else if (ena && !flush && exe_GPR_we_in && alu_overflow && !ovf_flag_q) begin
            ovf_flag_q <= 1'b1;
            ovf_epc_q  <= exe_pc_in;
        end
    end

    assign ovf_flag = ovf_flag_q;
    assign ovf_epc  = ovf_epc_q;
`else
    assign ovf_flag = 1'b0;
    assign ovf_epc  = 32'h0;
`endif

endmodule

// File: tb/tb_exe_mem_reg.sv
// tb_exe_mem_reg: directed-vector bench for exe_mem_reg.
// Expectations follow OVF_TRAP_EN the same way the design build does.
module tb_exe_mem_reg;

    logic        clk;
    logic        reset;
    logic        ena;
    logic        flush;
    logic [31:0] exe_alu_opr1_in;
    logic [31:0] exe_alu_opr2_in;
    logic [3:0]  exe_alu_control_in;
    logic        exe_GPR_we_in;
    logic [4:0]  exe_GPR_waddr_in;
    logic [1:0]  exe_GPR_wdata_select_in;
    logic [31:0] exe_GPR_rt_in;
    logic [31:0] exe_pc_in;
    logic [31:0] exe_instr_in;
    logic [31:0] exe_fwd_result;
    logic        exe_fwd_we;
    logic [31:0] mem_alu_result_out;
    logic [31:0] mem_GPR_rt_out;
    logic [31:0] mem_pc_out;
    logic [31:0] mem_instr_out;
    logic        mem_GPR_we;
    logic [4:0]  mem_GPR_waddr;
    logic [1:0]  mem_GPR_wdata_select;
    logic        ovf_flag;
    logic [31:0] ovf_epc;

    int tests_run = 0;
    int tests_failed = 0;

    exe_mem_reg dut (
        .clk                     (clk),
        .reset                   (reset),
        .ena                     (ena),
        .flush                   (flush),
        .exe_alu_opr1_in         (exe_alu_opr1_in),
        .exe_alu_opr2_in         (exe_alu_opr2_in),
        .exe_alu_control_in      (exe_alu_control_in),
        .exe_GPR_we_in           (exe_GPR_we_in),
        .exe_GPR_waddr_in        (exe_GPR_waddr_in),
        .exe_GPR_wdata_select_in (exe_GPR_wdata_select_in),
        .exe_GPR_rt_in           (exe_GPR_rt_in),
        .exe_pc_in               (exe_pc_in),
        .exe_instr_in            (exe_instr_in),
        .exe_fwd_result          (exe_fwd_result),
        .exe_fwd_we              (exe_fwd_we),
        .mem_alu_result_out      (mem_alu_result_out),
        .mem_GPR_rt_out          (mem_GPR_rt_out),
        .mem_pc_out              (mem_pc_out),
        .mem_instr_out           (mem_instr_out),
        .mem_GPR_we              (mem_GPR_we),
        .mem_GPR_waddr           (mem_GPR_waddr),
        .mem_GPR_wdata_select    (mem_GPR_wdata_select),
        .ovf_flag                (ovf_flag),
        .ovf_epc                 (ovf_epc)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle before sampling
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one EXE-stage instruction
    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [3:0] code,
                         input logic we, input logic [31:0] pc);
        exe_alu_opr1_in         = a;
        exe_alu_opr2_in         = b;
        exe_alu_control_in      = code;
        exe_GPR_we_in           = we;
        exe_GPR_waddr_in        = pc[6:2];
        exe_GPR_wdata_select_in = pc[3:2];
        exe_GPR_rt_in           = ~pc;
        exe_pc_in               = pc;
        exe_instr_in            = pc ^ 32'hA5A5_0000;
    endtask

    // Check every mem_* output against one expected instruction snapshot
    task automatic check_mem(input string tag, input logic [31:0] res, input logic we,
                             input logic [31:0] pc);
        check_eq({tag, ".result"}, mem_alu_result_out, res);
        check_eq({tag, ".we"},     {31'h0, mem_GPR_we}, {31'h0, we});
        check_eq({tag, ".pc"},     mem_pc_out, pc);
        check_eq({tag, ".rt"},     mem_GPR_rt_out, ~pc);
        check_eq({tag, ".instr"},  mem_instr_out, pc ^ 32'hA5A5_0000);
        check_eq({tag, ".waddr"},  {27'h0, mem_GPR_waddr}, {27'h0, pc[6:2]});
        check_eq({tag, ".wsel"},   {30'h0, mem_GPR_wdata_select}, {30'h0, pc[3:2]});
    endtask

    task automatic check_bubble(input string tag);
        check_eq({tag, ".result"}, mem_alu_result_out, 32'h0);
        check_eq({tag, ".we"},     {31'h0, mem_GPR_we}, 32'h0);
        check_eq({tag, ".pc"},     mem_pc_out, 32'h0);
        check_eq({tag, ".rt"},     mem_GPR_rt_out, 32'h0);
        check_eq({tag, ".instr"},  mem_instr_out, 32'h0);
        check_eq({tag, ".waddr"},  {27'h0, mem_GPR_waddr}, 32'h0);
        check_eq({tag, ".wsel"},   {30'h0, mem_GPR_wdata_select}, 32'h0);
    endtask

    // Directed ALU vectors: opr1, opr2, code, expected result, expected effective we
    logic [31:0] v_a   [14] = '{32'h0000_0004, 32'h0000_0004, 32'h0000_001F, 32'h0000_0020,
                                32'h0000_1234, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,
                                32'hF0F0_00FF, 32'hF0F0_00FF, 32'hF0F0_00FF, 32'hF0F0_00FF,
                                32'hF0F0_00FF, 32'hF0F0_00FF};
    logic [31:0] v_b   [14] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0001, 32'h0000_0005,
                                32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'h0000_ABCD,
                                32'h0FF0_0F0F, 32'h0FF0_0F0F, 32'h0FF0_0F0F, 32'h0FF0_0F0F,
                                32'h0FF0_0F0F, 32'h0FF0_0F0F};
    logic [3:0]  v_op  [14] = '{4'hD, 4'hC, 4'hE, 4'hE, 4'h1, 4'hA, 4'hB, 4'hF,
                                4'h6, 4'h7, 4'h8, 4'h9, 4'h3, 4'h5};
    logic [31:0] v_res [14] = '{32'hF800_0000, 32'h0800_0000, 32'h8000_0000, 32'h0000_0005,
                                32'h0000_1234, 32'h0000_0001, 32'h0000_0000, 32'hABCD_0000,
                                32'h00F0_000F, 32'hFFF0_0FFF, 32'hFF00_0FF0, 32'h000F_F000,
                                32'h00E0_100E, 32'hE0FF_F1F0};

    logic        exp_ovf_we;
    logic        exp_ovf_flag;
    logic [31:0] exp_ovf_epc;

    initial begin
`ifdef OVF_TRAP_EN
        exp_ovf_we   = 1'b0;
        exp_ovf_flag = 1'b1;
        exp_ovf_epc  = 32'h0000_0400;
`else
        exp_ovf_we   = 1'b1;
        exp_ovf_flag = 1'b0;
        exp_ovf_epc  = 32'h0;
`endif
        reset = 1'b0;
        ena   = 1'b1;
        flush = 1'b0;
        drive(32'h1111_1111, 32'h2222_2222, 4'h3, 1'b1, 32'h0000_0040);

        // Reset state
        step();
        check_bubble("reset");
        check_eq("reset.ovf_flag", {31'h0, ovf_flag}, 32'h0);
        check_eq("reset.ovf_epc", ovf_epc, 32'h0);
        reset = 1'b1;

        // ALU vectors with forwarding and one-cycle capture
        for (int i = 0; i < 14; i++) begin
            drive(v_a[i], v_b[i], v_op[i], 1'b1, 32'h0000_1000 + 32'(i * 4));
            #1;
            check_eq($sformatf("fwd_result[%0d]", i), exe_fwd_result, v_res[i]);
            check_eq($sformatf("fwd_we[%0d]", i), {31'h0, exe_fwd_we}, 32'h1);
            step();
            check_mem($sformatf("vec[%0d]", i), v_res[i], 1'b1, 32'h0000_1000 + 32'(i * 4));
        end

        // movn with zero condition suppresses the write
        drive(32'h0000_1234, 32'h0, 4'h1, 1'b1, 32'h0000_2000);
        #1;
        check_eq("movn0.fwd_we", {31'h0, exe_fwd_we}, 32'h0);
        step();
        check_mem("movn0", 32'h0000_1234, 1'b0, 32'h0000_2000);

        // NOP code never writes
        drive(32'h5, 32'h6, 4'h0, 1'b1, 32'h0000_2004);
        step();
        check_mem("nop", 32'h0, 1'b0, 32'h0000_2004);

        // we_in=0 passes through as 0
        drive(32'h5, 32'h6, 4'h3, 1'b0, 32'h0000_2008);
        step();
        check_mem("we_off", 32'h0000_000B, 1'b0, 32'h0000_2008);

        // Signed add overflow
        drive(32'h7FFF_FFFF, 32'h1, 4'h2, 1'b1, 32'h0000_0400);
        #1;
        check_eq("add_ovf.fwd_we", {31'h0, exe_fwd_we}, {31'h0, exp_ovf_we});
        step();
        check_mem("add_ovf", 32'h8000_0000, exp_ovf_we, 32'h0000_0400);
        check_eq("add_ovf.flag", {31'h0, ovf_flag}, {31'h0, exp_ovf_flag});
        check_eq("add_ovf.epc", ovf_epc, exp_ovf_epc);

        // Second overflow (sub) must not replace the first recorded PC
        drive(32'h8000_0000, 32'h1, 4'h4, 1'b1, 32'h0000_0500);
        step();
        check_mem("sub_ovf", 32'h7FFF_FFFF, exp_ovf_we, 32'h0000_0500);
        check_eq("sub_ovf.flag", {31'h0, ovf_flag}, {31'h0, exp_ovf_flag});
        check_eq("sub_ovf.epc", ovf_epc, exp_ovf_epc);

        // Reset mid-stream aborts the in-flight instruction
        reset = 1'b0;
        drive(32'h3, 32'h4, 4'h3, 1'b1, 32'h0000_0600);
        step();
        check_bubble("midrst");
        check_eq("midrst.flag", {31'h0, ovf_flag}, 32'h0);
        check_eq("midrst.epc", ovf_epc, 32'h0);
        reset = 1'b1;
        step();
        check_mem("after_rst", 32'h0000_0007, 1'b1, 32'h0000_0600);

        // ena=0 for three cycles holds everything
        ena = 1'b0;
        drive(32'h9, 32'h9, 4'h3, 1'b1, 32'h0000_0700);
        for (int c = 0; c < 3; c++) begin
            step();
            check_mem($sformatf("hold[%0d]", c), 32'h0000_0007, 1'b1, 32'h0000_0600);
        end

        // flush and ena together load a bubble
        ena   = 1'b1;
        flush = 1'b1;
        step();
        check_bubble("flush");

        // flush with ena=0 also clears; then normal capture resumes
        drive(32'h9, 32'h9, 4'h3, 1'b1, 32'h0000_0704);
        step();
        flush = 1'b0;
        step();
        check_mem("post_flush", 32'h0000_0012, 1'b1, 32'h0000_0704);
        ena = 1'b0;
        flush = 1'b1;
        step();
        check_bubble("flush_noena");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/exe_mem_reg.md
EXE_MEM_REG -- requirements
Module: exe_mem_reg

Interface
REQ-001 Parameters: none.
REQ-002 clk  in  1  rising-edge clock; one clock; reset is synchronous and active-low.
REQ-003 reset  in  1  synchronous active-low reset.
REQ-004 ena  in  1  pipeline advance enable from PipelineController.
REQ-005 flush  in  1  insert bubble into MEM stage.
REQ-006 exe_alu_opr1_in, exe_alu_opr2_in  in  32 each  ALU operands from ID/EXE register.
REQ-007 exe_alu_control_in  in  4  ALU op code (v2.0 encoding).
REQ-008 exe_GPR_we_in / exe_GPR_waddr_in / exe_GPR_wdata_select_in  in  1/5/2  write-back control.
REQ-009 exe_GPR_rt_in, exe_pc_in, exe_instr_in  in  32 each  store data, PC, instruction.
REQ-010 exe_fwd_result / exe_fwd_we  out  32/1  combinational ALU result and effective write enable, for forwarding.
REQ-011 mem_alu_result_out, mem_GPR_rt_out, mem_pc_out, mem_instr_out  out  32 each  registered.
REQ-012 mem_GPR_we / mem_GPR_waddr / mem_GPR_wdata_select  out  1/5/2  registered.
REQ-013 ovf_flag / ovf_epc  out  1/32  sticky overflow flag and faulting PC.

Function
REQ-014 ALU codes: 0001 movn=opr1; 0010 add; 0011 addu; 0100 sub; 0101 subu; 0110 and; 0111 or; 1000 xor; 1001 nor; 1010 slt signed; 1011 sltu; 1100 srl; 1101 sra; 1110 sll; 1111 lui={opr2[15:0],16'h0}; 0000 result 0.
REQ-015 Shifts: value=opr2, amount=opr1[4:0]; amounts 0 and 31 exact, no wrap beyond 5 bits.
REQ-016 add/sub wrap modulo 2^32; signed overflow = operands' sign rule on 32-bit result.
REQ-017 Effective we = exe_GPR_we_in AND NOT(code 0000) AND NOT(movn with opr2==0) AND NOT(add/sub overflow).
REQ-018 exe_fwd_result/exe_fwd_we reflect current inputs with zero latency.
REQ-019 Register update priority: reset, then flush, then ena; ena=0 and flush=0 holds all mem_* outputs.
REQ-020 flush=1 loads bubble: all mem_* outputs 0, regardless of ena.
REQ-021 ena=1: mem_* capture ALU result, effective we, and passthrough fields; latency exactly one cycle.

Reset
REQ-022 reset=0 at a rising edge clears every mem_* output, ovf_flag and ovf_epc to 0, aborting any in-flight instruction.
REQ-023 Outputs during reset are defined only after the first clk edge; no async path.

Configuration
REQ-024 Macro OVF_TRAP_EN defined: on ena=1, flush=0, exe_GPR_we_in=1 and add/sub overflow, ovf_flag sets and ovf_epc captures exe_pc_in, only if ovf_flag was 0 (first fault kept); cleared only by reset.
REQ-025 OVF_TRAP_EN undefined: add/sub behave as addu/subu (no write suppression), ovf_flag and ovf_epc tied 0.

Structure
REQ-026 Shared package mips31_pkg holds ALU code constants and wdata_select encodings; ID/EXE register uses the same constants.
REQ-027 One sub-module alu31: pure combinational ALU (opr1, opr2, control -> result, overflow, zero_opr2); register logic stays in exe_mem_reg.

Verification
REQ-028 opr1=7FFFFFFF, opr2=1, code 0010, we=1, ena=1 -> with OVF_TRAP_EN mem_GPR_we=0, ovf_flag=1, ovf_epc=PC; without: mem_alu_result_out=80000000, we=1.
REQ-029 opr1=4, opr2=80000000, code 1101 -> result F8000000; code 1100 -> 08000000; code 1110 with opr1=31, opr2=1 -> 80000000.
REQ-030 movn opr1=1234, opr2=0, we=1 -> mem_GPR_we=0; opr2=1 -> we=1, result 00001234.
REQ-031 flush=1 and ena=1 same cycle -> all mem_* 0 next cycle; ena=0 for 3 cycles -> outputs held unchanged.
REQ-032 slt opr1=FFFFFFFF, opr2=1 -> 1; sltu same -> 0; lui opr2=0000ABCD -> ABCD0000.
REQ-033 reset=0 one cycle after ovf_flag set, mid-stream -> all outputs 0 next edge, next valid instruction captured normally.
